// File: rtl/tdm_pkg.sv
// Shared constants, counter type and bit/slot/packing helpers for the TDM codec framer.
package tdm_pkg;

    localparam int unsigned FRAME_CLKS     = 256;
    localparam int unsigned BICK_PER_FRAME = 128;

    typedef logic [7:0] tdm_cnt_t;

    // BICK period index within the frame: two system clocks per bit.
    function automatic int unsigned bit_of_cnt(tdm_cnt_t cnt);
        return {25'd0, cnt[7:1]};
    endfunction

    function automatic int unsigned slot_of(tdm_cnt_t cnt, int unsigned slot_bits);
        return bit_of_cnt(cnt) / slot_bits;
    endfunction

    function automatic int unsigned pos_of(tdm_cnt_t cnt, int unsigned slot_bits);
        return bit_of_cnt(cnt) % slot_bits;
    endfunction

    // Flat index of bit k (MSB-first, k=0 is the MSB) of channel slot in a packed frame.
    function automatic int unsigned pack_idx(int unsigned slot, int unsigned k, int unsigned w);
        return slot * w + (w - 1 - k);
    endfunction

endpackage

// File: rtl/tdm_frame_counter.sv
// Free-running 256-clock frame counter producing registered BICK and LRCK plus a frame_end strobe.
module tdm_frame_counter
    import tdm_pkg::*;
(
    input  logic       clk_256fs,
    input  logic       rst_n,
    output logic [7:0] cnt,
    output logic [7:0] cnt_next,
    output logic       bick,
    output logic       lrck,
    output logic       frame_end
);

    tdm_cnt_t cnt_q, cnt_d;
    logic     bick_q, lrck_q;

    assign cnt_d = cnt_q + 8'd1;

    // BICK and LRCK are registered from the next count so they line up with cnt.
    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bick_q <= 1'b0;
            lrck_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bick_q <= cnt_d[0];
            lrck_q <= (cnt_d[7:1] == 7'd0);
        end
    end

    assign cnt       = cnt_q;
    assign cnt_next  = cnt_d;
    assign bick      = bick_q;
    assign lrck      = lrck_q;
    assign frame_end = (cnt_q == tdm_cnt_t'(FRAME_CLKS - 1));

endmodule

// File: rtl/tdm_codec_frame.sv
// Codec-side TDM framer: serialises DAC frames onto sdout and deserialises ADC frames from sdin.
// Define TDM_LOOPBACK_EN to capture the internal sdout instead of the sdin pin.
module tdm_codec_frame
    import tdm_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned NCH       = 4,
    parameter int unsigned SLOT_BITS = 32
) (
    input  logic             clk_256fs,
    input  logic             rst_n,
    output logic             bick,
    output logic             lrck,
    output logic             sdout,
    input  logic             sdin,
    input  logic [NCH*W-1:0] dac_data,
    input  logic             dac_valid,
    output logic             dac_ready,
    output logic [NCH*W-1:0] adc_data,
    output logic             adc_valid,
    output logic             underrun
);

    localparam int unsigned FrameBits = NCH * W;
    localparam int unsigned IdxW      = (FrameBits > 1) ? $clog2(FrameBits) : 1;

    if ((NCH * SLOT_BITS != BICK_PER_FRAME) || (W < 1) || (W > 32) || (W > SLOT_BITS))
    begin : g_cfg_err
        $error("tdm_codec_frame: need NCH*SLOT_BITS == %0d and 1 <= W <= min(32, SLOT_BITS)",
               BICK_PER_FRAME);
    end

    logic [7:0] cnt, cnt_next;
    logic       frame_end;

    tdm_frame_counter u_frame_counter (
        .clk_256fs (clk_256fs),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .cnt_next  (cnt_next),
        .bick      (bick),
        .lrck      (lrck),
        .frame_end (frame_end)
    );

    logic [FrameBits-1:0] hold_q, hold_d;
    logic [FrameBits-1:0] tx_q, tx_d;
    logic [FrameBits-1:0] rx_q, rx_d;
    logic [FrameBits-1:0] adc_q, adc_d;
    logic                 ready_q, ready_d;
    logic                 sdout_q, sdout_d;
    logic                 adc_valid_q, adc_valid_d;
    logic                 underrun_q, underrun_d;
    logic                 rx_bit;

    int unsigned tx_slot, tx_pos, rx_slot, rx_pos;

`ifdef TDM_LOOPBACK_EN
    logic unused_sdin;
    assign unused_sdin = sdin;
    assign rx_bit      = sdout_q;
`else
    assign rx_bit = sdin;
`endif

    // Holding register state is carried by ready_q: ready_q == 1 means empty.
    always_comb begin
        hold_d      = hold_q;
        ready_d     = ready_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        adc_d       = adc_q;
        sdout_d     = sdout_q;
        underrun_d  = frame_end && ready_q;
        adc_valid_d = frame_end;
        tx_slot     = slot_of(cnt_next, SLOT_BITS);
        tx_pos      = pos_of(cnt_next, SLOT_BITS);
        rx_slot     = slot_of(cnt, SLOT_BITS);
        rx_pos      = pos_of(cnt, SLOT_BITS);

        if (frame_end && !ready_q) begin
            tx_d    = hold_q;
            ready_d = 1'b1;
        end

        // On a boundary with an empty holding register this loads the next frame's word.
        if (dac_valid && ready_q) begin
            hold_d  = dac_data;
            ready_d = 1'b0;
        end

        // Capture at the end of the BICK-high phase, before the frame copy below.
        if (cnt[0] && (rx_pos < W)) begin
            rx_d[IdxW'(pack_idx(rx_slot, rx_pos, W))] = rx_bit;
        end

        if (frame_end) begin
            adc_d = rx_d;
        end

        // New data launches on BICK falling, using the frame being loaded this edge.
        if (!cnt_next[0]) begin
            sdout_d = (tx_pos < W) ? tx_d[IdxW'(pack_idx(tx_slot, tx_pos, W))] : 1'b0;
        end
    end

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            ready_q     <= 1'b1;
            tx_q        <= '0;
            rx_q        <= '0;
            adc_q       <= '0;
            sdout_q     <= 1'b0;
            adc_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            adc_q       <= adc_d;
            sdout_q     <= sdout_d;
            adc_valid_q <= adc_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sdout     = sdout_q;
    assign dac_ready = ready_q;
    assign adc_data  = adc_q;
    assign adc_valid = adc_valid_q;
    assign underrun  = underrun_q;

endmodule
